// File: rtl/key_conditioner_if.sv
// Push-button bundle between the board keys and the stopwatch control logic.
// The release pulse is carried on release_pulse.
interface key_conditioner_if #(
  parameter int unsigned NKEYS = 2
);
  logic [NKEYS-1:0] key_n;
  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] release_pulse;
  logic [NKEYS-1:0] long_press;

  modport master (
    output key_n,
    input  level,
    input  press,
    input  release_pulse,
    input  long_press
  );

  modport slave (
    input  key_n,
    output level,
    output press,
    output release_pulse,
    output long_press
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, debouncer and press/release/long-press pulse generator.
// Channels are identical and independent; all outputs come straight from flops.
module key_conditioner #(
  parameter int unsigned NKEYS           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  key_conditioner_if.slave   kif
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } state_t;

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          raw;
    logic [DW-1:0] dcnt;
    logic          level_q;
    logic          accept;
    logic          hold_done;
    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nxt;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          press_nxt;
    logic          release_nxt;
    logic          long_nxt;

    // Two-flop synchroniser; reset value is the released (high) level
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
      end else begin
        s1 <= kif.key_n[i];
        s2 <= s1;
      end
    end

    assign raw    = ~s2;
    assign accept = (raw != level_q) && (dcnt == DCNT_LAST);

    // Debounce: a new level is accepted only after an unbroken run of differing samples
    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt    <= '0;
        level_q <= 1'b0;
      end else if (raw == level_q) begin
        dcnt    <= '0;
      end else if (dcnt == DCNT_LAST) begin
        dcnt    <= '0;
        level_q <= ~level_q;
      end else begin
        dcnt    <= dcnt + DW'(1);
      end
    end

    // hcnt only ever reaches HCNT_LAST-1 in PRESSED, so the increment cannot wrap
    assign hold_done = (hcnt + HW'(1)) == HCNT_LAST;

    // State, hold counter and output registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= ST_RELEASED;
        hcnt      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nxt;
        hcnt      <= hcnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
      end
    end

    // Next state; an accepted release always takes priority over the long-press timeout
    always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      unique case (state)
        ST_RELEASED: begin
          if (accept) begin
            state_nxt = ST_PRESSED;
            hcnt_nxt  = '0;
          end
        end
        ST_PRESSED: begin
          if (accept) begin
            state_nxt = ST_RELEASED;
          end else begin
            hcnt_nxt = hcnt + HW'(1);
            if (hold_done) begin
              state_nxt = ST_LONG;
            end
          end
        end
        ST_LONG: begin
          if (accept) begin
            state_nxt = ST_RELEASED;
          end
        end
        default: begin
          state_nxt = ST_RELEASED;
          hcnt_nxt  = '0;
        end
      endcase
    end

    // Pulse decode, registered alongside the state transition
    always_comb begin
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      unique case (state)
        ST_RELEASED: press_nxt   = accept;
        ST_PRESSED: begin
          release_nxt = accept;
          long_nxt    = ~accept & hold_done;
        end
        ST_LONG:     release_nxt = accept;
        default: begin
          press_nxt   = 1'b0;
          release_nxt = 1'b0;
          long_nxt    = 1'b0;
        end
      endcase
    end

    assign kif.level[i]         = level_q;
    assign kif.press[i]         = press_q;
    assign kif.release_pulse[i] = release_q;
    assign kif.long_press[i]    = long_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a sliding-window behavioural model
// checked every cycle, plus literal timing expectations for each scenario.
module tb_key_conditioner;
  localparam int unsigned NK = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned L  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_conditioner_if #(.NKEYS(NK)) kif ();

  key_conditioner #(
    .NKEYS(NK),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic [NK-1:0] m_level, m_press, m_rel, m_long;
  logic [NK-1:0] dl1, dl2;
  logic [D-1:0]  win [NK];
  int            press_cyc [NK];

  logic [NK-1:0] acc_press, acc_rel;
  int            long_cnt;

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // Model: a level flips once the last D raw samples all disagree with it
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
      dl1 = '1; dl2 = '1;
      for (int i = 0; i < NK; i++) begin
        win[i] = '0;
        press_cyc[i] = 0;
      end
    end else begin
      for (int i = 0; i < NK; i++) begin
        logic r;
        r = ~dl2[i];
        win[i] = {win[i][D-2:0], r};
        m_press[i] = 1'b0;
        m_rel[i]   = 1'b0;
        m_long[i]  = 1'b0;
        if (win[i] == {D{~m_level[i]}}) begin
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin
            m_press[i]   = 1'b1;
            press_cyc[i] = cyc;
          end else begin
            m_rel[i] = 1'b1;
          end
        end else if (m_level[i] && (cyc - press_cyc[i] == int'(L) - 1)) begin
          m_long[i] = 1'b1;
        end
      end
      dl2 = dl1;
      dl1 = kif.key_n;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_level",   kif.level,         m_level);
      check("model_press",   kif.press,         m_press);
      check("model_release", kif.release_pulse, m_rel);
      check("model_long",    kif.long_press,    m_long);
      acc_press = acc_press | kif.press;
      acc_rel   = acc_rel | kif.release_pulse;
      long_cnt  = long_cnt + $countones(kif.long_press);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    acc_press = '0;
    acc_rel   = '0;
    long_cnt  = 0;
    rst       = 1'b1;
    kif.key_n = '1;
    tick(3);
    check("rst_level",   kif.level,         2'b00);
    check("rst_press",   kif.press,         2'b00);
    check("rst_release", kif.release_pulse, 2'b00);
    check("rst_long",    kif.long_press,    2'b00);
    chk_en = 1'b1;
    rst    = 1'b0;
    tick(50);
    check("idle_no_press", acc_press | acc_rel, 2'b00);
    check("idle_no_long",  NK'(long_cnt), 2'b00);

    // Single press on key 1: first sampling edge E0 is the next edge
    kif.key_n[1] = 1'b0;
    tick(5);
    check("k1_press_early", kif.press, 2'b00);
    tick(1);
    check("k1_press_e0p5", kif.press, 2'b10);
    check("k1_level_e0p5", kif.level, 2'b10);
    tick(1);
    check("k1_press_1cyc", kif.press, 2'b00);
    check("k1_level_held", kif.level, 2'b10);
    kif.key_n[1] = 1'b1;
    tick(6);
    check("k1_release", kif.release_pulse, 2'b10);
    check("k1_level_off", kif.level, 2'b00);
    tick(4);

    // Bounce: 3-cycle low excursions never reach the 4-sample threshold
    acc_press = '0;
    repeat (5) begin
      kif.key_n[1] = 1'b0;
      tick(3);
      kif.key_n[1] = 1'b1;
      tick(2);
    end
    tick(8);
    check("glitch_no_press", acc_press, 2'b00);
    check("glitch_level",    kif.level, 2'b00);

    // Long hold of key 0 for 30 edges
    long_cnt = 0;
    kif.key_n[0] = 1'b0;
    tick(6);
    check("k0_press", kif.press, 2'b01);
    tick(8);
    check("k0_long_early", kif.long_press, 2'b00);
    tick(1);
    check("k0_long_p9", kif.long_press, 2'b01);
    tick(15);
    kif.key_n[0] = 1'b1;
    tick(5);
    check("k0_rel_early", kif.release_pulse, 2'b00);
    tick(1);
    check("k0_release", kif.release_pulse, 2'b01);
    check("k0_long_once", NK'(long_cnt), NK'(1));
    tick(5);

    // Release accepted on the very edge long-press would fire: release wins
    long_cnt = 0;
    kif.key_n[0] = 1'b0;
    tick(9);
    kif.key_n[0] = 1'b1;
    tick(5);
    check("race_rel_early", kif.release_pulse, 2'b00);
    tick(1);
    check("race_release", kif.release_pulse, 2'b01);
    check("race_no_long", kif.long_press, 2'b00);
    tick(5);
    check("race_long_cnt", NK'(long_cnt), 2'b00);

    // Reset while key 1 is debounced-pressed, key kept low through reset
    kif.key_n[1] = 1'b0;
    tick(7);
    check("rsthold_level", kif.level, 2'b10);
    acc_rel = '0;
    rst = 1'b1;
    tick(1);
    check("rsthold_level_off", kif.level, 2'b00);
    check("rsthold_no_rel", kif.release_pulse, 2'b00);
    rst = 1'b0;
    tick(5);
    check("rsthold_press_early", kif.press, 2'b00);
    tick(1);
    check("rsthold_repress", kif.press, 2'b10);
    check("rsthold_acc_rel", acc_rel, 2'b00);
    kif.key_n[1] = 1'b1;
    tick(10);

    // Both keys on the same edge
    kif.key_n = '0;
    tick(6);
    check("both_press", kif.press, 2'b11);
    check("both_level", kif.level, 2'b11);
    tick(2);
    kif.key_n = '1;
    tick(20);
    check("end_level", kif.level, 2'b00);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
